// File: rtl/mux4x1.sv
// 4-to-1 datapath multiplexer with registered result and select code.
// Optional build macro MUX4X1_PARITY_EN adds a registered even-parity output par_q.
module mux4x1 #(
    parameter int WIDTH = 1
) (
    output logic [WIDTH-1:0] Y,
    input  logic [WIDTH-1:0] A0,
    input  logic [WIDTH-1:0] A1,
    input  logic [WIDTH-1:0] A2,
    input  logic [WIDTH-1:0] A3,
    input  logic             S0,
    input  logic             S1,
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] Y_q,
    output logic [1:0]       sel_q
`ifdef MUX4X1_PARITY_EN
    ,
    output logic             par_q
`endif
);

    logic [1:0] sel;

    assign sel = {S1, S0};

    // An unknown select yields all-X rather than a blend of two candidates.
    always_comb begin
        Y = 'x;
        case (sel)
            2'b00:   Y = A0;
            2'b01:   Y = A1;
            2'b10:   Y = A2;
            2'b11:   Y = A3;
            default: Y = 'x;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            Y_q   <= '0;
            sel_q <= 2'b00;
        end else begin
            Y_q   <= Y;
            sel_q <= sel;
        end
    end

`ifdef MUX4X1_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            par_q <= 1'b0;
        end else begin
            par_q <= ^Y;
        end
    end
`endif

endmodule

// File: tb/tb_mux4x1.sv
// Directed self-checking bench for mux4x1: combinational select at WIDTH=1,
// registered path and synchronous reset at WIDTH=8 (plus par_q when MUX4X1_PARITY_EN is set).
module tb_mux4x1;

    logic       clk = 1'b0;
    logic       reset;

    logic       y1, a0_1, a1_1, a2_1, a3_1, s0_1, s1_1, yq_1;
    logic [1:0] selq_1;

    logic [7:0] y8, a0_8, a1_8, a2_8, a3_8, yq_8;
    logic       s0_8, s1_8;
    logic [1:0] selq_8;

`ifdef MUX4X1_PARITY_EN
    logic       par_1, par_8;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux4x1 #(.WIDTH(1)) u_w1 (
        .Y(y1), .A0(a0_1), .A1(a1_1), .A2(a2_1), .A3(a3_1),
        .S0(s0_1), .S1(s1_1), .clk(clk), .reset(reset),
        .Y_q(yq_1), .sel_q(selq_1)
`ifdef MUX4X1_PARITY_EN
        , .par_q(par_1)
`endif
    );

    mux4x1 #(.WIDTH(8)) u_w8 (
        .Y(y8), .A0(a0_8), .A1(a1_8), .A2(a2_8), .A3(a3_8),
        .S0(s0_8), .S1(s1_8), .clk(clk), .reset(reset),
        .Y_q(yq_8), .sel_q(selq_8)
`ifdef MUX4X1_PARITY_EN
        , .par_q(par_8)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] hot;
        logic [1:0] sv;

        reset = 1'b1;
        a0_1 = 1'b1; a1_1 = 1'b0; a2_1 = 1'b0; a3_1 = 1'b0;
        s0_1 = 1'b0; s1_1 = 1'b0;
        a0_8 = 8'h11; a1_8 = 8'h22; a2_8 = 8'h33; a3_8 = 8'h44;
        s0_8 = 1'b0; s1_8 = 1'b1;

        // Combinational path, WIDTH=1
        #1;
        check("w1_sel0", {63'b0, y1}, 64'd1);
        #20;
        check("w1_sel0_hold", {63'b0, y1}, 64'd1);

        a0_1 = 1'b0; a1_1 = 1'b1; s0_1 = 1'b1; s1_1 = 1'b0;
        #1;
        check("w1_sel1", {63'b0, y1}, 64'd1);
        a1_1 = 1'b0;
        #1;
        check("w1_sel1_track", {63'b0, y1}, 64'd0);

        a2_1 = 1'b1; s0_1 = 1'b0; s1_1 = 1'b1;
        #1;
        check("w1_sel2", {63'b0, y1}, 64'd1);
        a2_1 = 1'b0; a3_1 = 1'b1; s0_1 = 1'b1; s1_1 = 1'b1;
        #1;
        check("w1_sel3", {63'b0, y1}, 64'd1);

        for (int i = 0; i < 4; i++) begin
            hot = 4'b0001 << i;
            {a3_1, a2_1, a1_1, a0_1} = hot;
            for (int j = 0; j < 4; j++) begin
                sv = 2'(j);
                {s1_1, s0_1} = sv;
                #1;
                check($sformatf("w1_onehot%0d_sel%0d", i, j), {63'b0, y1}, {63'b0, hot[j]});
            end
        end

        // Comb output valid while reset is held
        check("w8_comb_in_reset", {56'b0, y8}, 64'h33);

        // Registered path, WIDTH=8: two reset edges
        s0_8 = 1'b1; s1_8 = 1'b1;
        tick();
        tick();
        check("w8_reset_yq", {56'b0, yq_8}, 64'h00);
        check("w8_reset_selq", {62'b0, selq_8}, 64'd0);

        reset = 1'b0;
        s0_8 = 1'b0; s1_8 = 1'b0;
        #1;
        check("w8_no_early_update", {56'b0, yq_8}, 64'h00);
        tick();
        check("w8_sweep0_yq", {56'b0, yq_8}, 64'h11);
        check("w8_sweep0_selq", {62'b0, selq_8}, 64'd0);

        s0_8 = 1'b1; s1_8 = 1'b0;
        #1;
        check("w8_latency_hold", {56'b0, yq_8}, 64'h11);
        tick();
        check("w8_sweep1_yq", {56'b0, yq_8}, 64'h22);
        check("w8_sweep1_selq", {62'b0, selq_8}, 64'd1);

        s0_8 = 1'b0; s1_8 = 1'b1;
        tick();
        check("w8_sweep2_yq", {56'b0, yq_8}, 64'h33);
        check("w8_sweep2_selq", {62'b0, selq_8}, 64'd2);

        s0_8 = 1'b1; s1_8 = 1'b1;
        tick();
        check("w8_sweep3_yq", {56'b0, yq_8}, 64'h44);
        check("w8_sweep3_selq", {62'b0, selq_8}, 64'd3);

        // Mid-run reset asserted between edges
        #2;
        reset = 1'b1;
        #1;
        check("w8_midreset_between", {56'b0, yq_8}, 64'h44);
        check("w8_midreset_between_sel", {62'b0, selq_8}, 64'd3);
        tick();
        check("w8_midreset_yq", {56'b0, yq_8}, 64'h00);
        check("w8_midreset_selq", {62'b0, selq_8}, 64'd0);
        reset = 1'b0;
        tick();
        check("w8_after_reset_yq", {56'b0, yq_8}, 64'h44);
        check("w8_after_reset_selq", {62'b0, selq_8}, 64'd3);

`ifdef MUX4X1_PARITY_EN
        s0_8 = 1'b1; s1_8 = 1'b0;
        a1_8 = 8'h07;
        tick();
        check("par_07", {63'b0, par_8}, 64'd1);
        a1_8 = 8'h03;
        tick();
        check("par_03", {63'b0, par_8}, 64'd0);
        a1_8 = 8'h07;
        tick();
        check("par_07_again", {63'b0, par_8}, 64'd1);
        reset = 1'b1;
        tick();
        check("par_reset", {63'b0, par_8}, 64'd0);
        reset = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux4x1.md
Name: mux4x1

Overview:
- 4-to-1 multiplexer for datapath operand/writeback selection in the single-cycle MIPS processor.
- Combinational output Y selects one of four data inputs using the two select bits {S1,S0}.
- A registered copy of the result and of the select code is also provided for pipelining and debug.
- Clocked portion: one clock; reset is synchronous and active-high (ports clk, reset).

Parameters:
WIDTH, 1, bit width of each data input and of Y/Y_q (legal 1..64)

Ports:
clk      input   1            rising-edge clock for registered outputs
reset    input   1            synchronous, active-high reset
Y        output  WIDTH        combinational mux result
A0       input   WIDTH        data input, selected when {S1,S0}=2'b00
A1       input   WIDTH        data input, selected when {S1,S0}=2'b01
A2       input   WIDTH        data input, selected when {S1,S0}=2'b10
A3       input   WIDTH        data input, selected when {S1,S0}=2'b11
S0       input   1            select bit 0 (LSB)
S1       input   1            select bit 1 (MSB)
Y_q      output  WIDTH        Y registered on clk rising edge
sel_q    output  2            {S1,S0} registered on clk rising edge

Behaviour:
- Y = A0/A1/A2/A3 for {S1,S0} = 00/01/10/11. Purely combinational, zero cycle latency, no clock dependence.
- Y tracks any change on the data inputs or select bits within the same delta. It is valid even while reset is asserted.
- S0 is the LSB. Example: S0=1, S1=0 selects A1.
- Unknown or high-Z select handling:
  - If either select bit is X/Z, Y = all-X (simulation) and the two candidate inputs are not merged.
  - Synthesis treats the select bits as 2-state.
- Registered path, at each rising edge of clk:
  - If reset=1: Y_q <= 0 and sel_q <= 2'b00.
  - Else: Y_q <= Y and sel_q <= {S1,S0}.
- Latency of Y_q and sel_q is 1 cycle from input change to output update.
- Reset is synchronous: asserting reset between edges does not change Y_q/sel_q until the next edge.
- Reset asserted mid-stream clears both registers on that edge. The first edge after deassertion captures the current Y.
- Power-up values of Y_q/sel_q are undefined until the first reset edge.
- Port order for positional instantiation: Y, A0, A1, A2, A3, S0, S1, then clk, reset, Y_q, sel_q. Existing 7-port positional instances must remain legal; trailing ports may be left unconnected.
- If clk is unconnected, Y_q/sel_q are don't-care and Y remains fully functional.

Optional Feature:
- Macro: MUX4X1_PARITY_EN.
- When defined:
  - Adds output port par_q (1 bit, last in the port list).
  - At each clk edge: par_q <= 0 on reset, otherwise the XOR-reduction of Y (even parity of the selected data).
  - Has the same 1-cycle latency as Y_q.
- When undefined: port par_q and its logic are absent. All other behaviour is identical.

Test Plan:
- WIDTH=1, A0=1, A1=0, A2=0, A3=0, S0=0, S1=0 -> Y=1. Hold 20 time units; Y stays 1.
- A0=0, A1=1, A2=0, A3=0, S0=1, S1=0 -> Y=1. Change A1 to 0 with select held -> Y=0 immediately.
- A2=1 (others 0), S0=0, S1=1 -> Y=1; then A3=1 (others 0), S0=1, S1=1 -> Y=1. Across all four one-hot patterns, a mismatched select gives Y=0.
- Clocked path, WIDTH=8, A0..A3 = 8'h11/8'h22/8'h33/8'h44:
  - Hold reset=1 for 2 edges -> Y_q=8'h00, sel_q=0.
  - Release reset, sweep sel 0..3 one per cycle -> Y_q = 11, 22, 33, 44 on successive edges, each one cycle after the select change; sel_q follows.
- Mid-run reset: assert reset between edges with sel=3 -> Y_q is unchanged until the next edge, then 8'h00. Deassert reset -> the next edge gives Y_q=8'h44.
- With MUX4X1_PARITY_EN, WIDTH=8, sel=2'b01, A1=8'h07 -> par_q=1 one cycle later. With A1=8'h03 -> par_q=0. Reset forces par_q=0.
